seg_scan_counter: RTL

//  Consumer of the divided clocks: counts slow steps in BCD, multiplexes the count onto a 4-digit 7-seg display.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/edge_sync.sv | 41 ++++
 rtl/seg_scan_counter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and the 7-segment decoder for the scanned BCD display.
// The decoder returns active-high {g,f,e,d,c,b,a}; output polarity is applied by the user.
package seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  function automatic seg7_t bcd_to_seg(input logic [3:0] digit);
    seg7_t pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes a slow level input into clk_sys and emits a one-cycle tick on each rising edge.
// Ticks are suppressed until the history flop holds a real sample, so a level already high at reset release is ignored.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic d,
  output logic tick
);

  localparam int ARM = SYNC_STAGES + 1;
  localparam int AW  = $clog2(ARM + 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [AW-1:0]          arm_r;
  logic                   tick_r;

  // Synchronizer chain, edge history, arming counter and registered tick.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
      arm_r  <= {AW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
      if (arm_r != AW'(ARM)) begin
        arm_r <= arm_r + AW'(1);
      end else begin
        arm_r <= arm_r;
      end
      tick_r <= (arm_r == AW'(ARM)) && sync_r[SYNC_STAGES-1] && !prev_r;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/seg_scan_counter.sv
// BCD step counter driven by a synchronized slow clock, shown on a multiplexed 7-segment display.
// Anode, segment and decimal-point registers are loaded together from the same index/count sample.
module seg_scan_counter
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic                  step_clk,
  input  logic                  run,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int               IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic             POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF = POL_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam seg7_t            SEG_OFF = POL_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic             DP_OFF  = POL_LOW;

  logic                scan_tick_s;
  logic                step_tick_s;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] bcd_inc_s;
  logic                inc_carry_s;
  logic                carry_r;
  logic [IW-1:0]       idx_r;
  logic [IW-1:0]       idx_next_s;
  logic                lit_r;
  logic                lit_next_s;
  logic                zero_above_s;
  logic [3:0]          digit_s;
  logic                digit_blank_s;
  logic [DIGITS-1:0]   an_hi_s;
  seg7_t               seg_hi_s;
  logic [DIGITS-1:0]   an_r;
  seg7_t               seg_r;
  logic                dp_r;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scan_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .d       (scan_clk),
    .tick    (scan_tick_s)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .d       (step_clk),
    .tick    (step_tick_s)
  );

  // Ripple BCD increment; inc_carry_s survives the loop only when every digit was 9.
  always_comb begin
    bcd_inc_s   = bcd_r;
    inc_carry_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry_s) begin
        if (bcd_r[4*i +: 4] == 4'd9) begin
          bcd_inc_s[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd1;
          inc_carry_s         = 1'b0;
        end
      end else begin
        bcd_inc_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  // Count register: clear beats step, a step with run low is dropped.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      bcd_r   <= {(4*DIGITS){1'b0}};
      carry_r <= 1'b0;
    end else if (clr) begin
      bcd_r   <= {(4*DIGITS){1'b0}};
      carry_r <= 1'b0;
    end else if (step_tick_s && run) begin
      bcd_r   <= bcd_inc_s;
      carry_r <= inc_carry_s;
    end else begin
      carry_r <= 1'b0;
    end
  end

  // The first scan tick only lights digit 0; later ticks advance the index.
  always_comb begin
    idx_next_s = idx_r;
    if (scan_tick_s && lit_r) begin
      if (idx_r == IW'(DIGITS - 1)) begin
        idx_next_s = {IW{1'b0}};
      end else begin
        idx_next_s = idx_r + IW'(1);
      end
    end else begin
      idx_next_s = idx_r;
    end
    lit_next_s = lit_r | scan_tick_s;
  end

  // Select and decode the digit at the next index, blanking leading zeros above digit 0.
  always_comb begin
    zero_above_s  = 1'b1;
    digit_s       = 4'd0;
    digit_blank_s = 1'b0;
    an_hi_s       = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s && (bcd_r[4*k +: 4] == 4'd0);
      if (idx_next_s == IW'(k)) begin
        digit_s       = bcd_r[4*k +: 4];
        digit_blank_s = (BLANK_LZ != 0) && (k != 0) && zero_above_s;
        an_hi_s[k]    = 1'b1;
      end else begin
        an_hi_s[k]    = 1'b0;
      end
    end
    seg_hi_s = digit_blank_s ? SEG_BLANK : bcd_to_seg(digit_s);
  end

  // Scan state and display output registers, dark until the first scan tick.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      idx_r <= {IW{1'b0}};
      lit_r <= 1'b0;
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
      dp_r  <= DP_OFF;
    end else begin
      idx_r <= idx_next_s;
      lit_r <= lit_next_s;
      if (lit_next_s) begin
        an_r  <= POL_LOW ? ~an_hi_s : an_hi_s;
        seg_r <= POL_LOW ? ~seg_hi_s : seg_hi_s;
        dp_r  <= ((idx_next_s == {IW{1'b0}}) && !run) ? ~DP_OFF : DP_OFF;
      end else begin
        an_r  <= AN_OFF;
        seg_r <= SEG_OFF;
        dp_r  <= DP_OFF;
      end
    end
  end

  assign bcd   = bcd_r;
  assign carry = carry_r;
  assign an    = an_r;
  assign seg   = seg_r;
  assign dp    = dp_r;

endmodule
